// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined WORD_SIZE add/subtract, one CHUNK_SIZE slice per stage, carry registered between stages.
// Define ADDSUB_PIPE_SAT_EN to add the sat port and clamp the result on signed overflow.
module addsub_pipe #(
    parameter int WORD_SIZE  = 16,
    parameter int CHUNK_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] x,
    input  logic [WORD_SIZE-1:0] y,
    input  logic                 sub,
    input  logic                 cin,
    input  logic                 carry,
`ifdef ADDSUB_PIPE_SAT_EN
    input  logic                 sat,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);
    localparam int STAGES = WORD_SIZE / CHUNK_SIZE;
    localparam int LAST   = STAGES - 1;

    logic [STAGES-1:0]    valid_r;
    logic [STAGES-1:0]    carry_r;
    logic [STAGES-1:0]    c_nxt_s;
    logic [WORD_SIZE-1:0] sum_r;
    logic                 ovf_r;
    logic                 stall_s;
    logic                 adv_s;
    logic                 accept_s;
    logic                 c0_s;
    logic [WORD_SIZE-1:0] y_op_s;

    // Handshake decode and stage-0 operand conditioning
    always_comb begin
        stall_s  = valid_r[LAST] & ~out_ready;
        adv_s    = ~stall_s;
        accept_s = in_valid & adv_s;
        y_op_s   = sub ? ~y : y;
        c0_s     = carry ? cin : sub;
    end

    assign in_ready  = adv_s;
    assign out_valid = valid_r[LAST];
    assign sum       = sum_r;
    assign cout      = carry_r[LAST];
    assign ovf       = ovf_r;

    // Valid bits and inter-stage carries advance together; a stall freezes the whole pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {STAGES{1'b0}};
            carry_r <= {STAGES{1'b0}};
        end else if (adv_s) begin
            valid_r <= (valid_r << 1'b1) | STAGES'(accept_s);
            carry_r <= c_nxt_s;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int RW = WORD_SIZE - k * CHUNK_SIZE;

        logic [RW-1:0]                 in_x_s;
        logic [RW-1:0]                 in_y_s;
        logic                          in_c_s;
        logic [CHUNK_SIZE:0]           add_s;
        logic [(k+1)*CHUNK_SIZE-1:0]   nsum_s;
`ifdef ADDSUB_PIPE_SAT_EN
        logic                          in_sat_s;
`endif

        if (k == 0) begin : g_src
            assign in_x_s = x;
            assign in_y_s = y_op_s;
            assign in_c_s = c0_s;
            assign nsum_s = add_s[CHUNK_SIZE-1:0];
`ifdef ADDSUB_PIPE_SAT_EN
            assign in_sat_s = sat;
`endif
        end else begin : g_src
            assign in_x_s = g_stage[k-1].g_fwd.xr_r;
            assign in_y_s = g_stage[k-1].g_fwd.yr_r;
            assign in_c_s = carry_r[k-1];
            assign nsum_s = {add_s[CHUNK_SIZE-1:0], g_stage[k-1].g_fwd.psum_r};
`ifdef ADDSUB_PIPE_SAT_EN
            assign in_sat_s = g_stage[k-1].g_fwd.sat_r;
`endif
        end

        // The low slice of the remaining operands is the one this stage consumes
        assign add_s = {1'b0, in_x_s[CHUNK_SIZE-1:0]}
                     + {1'b0, in_y_s[CHUNK_SIZE-1:0]}
                     + {{CHUNK_SIZE{1'b0}}, in_c_s};
        assign c_nxt_s[k] = add_s[CHUNK_SIZE];

        if (k < LAST) begin : g_fwd
            logic [RW-CHUNK_SIZE-1:0]    xr_r;
            logic [RW-CHUNK_SIZE-1:0]    yr_r;
            logic [(k+1)*CHUNK_SIZE-1:0] psum_r;
`ifdef ADDSUB_PIPE_SAT_EN
            logic                        sat_r;
`endif
            // Stage register: finished low slices plus the operand slices still to be added
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    xr_r   <= {(RW-CHUNK_SIZE){1'b0}};
                    yr_r   <= {(RW-CHUNK_SIZE){1'b0}};
                    psum_r <= {((k+1)*CHUNK_SIZE){1'b0}};
`ifdef ADDSUB_PIPE_SAT_EN
                    sat_r  <= 1'b0;
`endif
                end else if (adv_s) begin
                    xr_r   <= in_x_s[RW-1:CHUNK_SIZE];
                    yr_r   <= in_y_s[RW-1:CHUNK_SIZE];
                    psum_r <= nsum_s;
`ifdef ADDSUB_PIPE_SAT_EN
                    sat_r  <= in_sat_s;
`endif
                end
            end
        end else begin : g_out
            logic                 ovf_s;
            logic [WORD_SIZE-1:0] res_s;

            // Signed overflow: equal operand signs but a different result sign
            always_comb begin
                ovf_s = (in_x_s[CHUNK_SIZE-1] == in_y_s[CHUNK_SIZE-1]) &&
                        (add_s[CHUNK_SIZE-1] != in_x_s[CHUNK_SIZE-1]);
                res_s = nsum_s;
`ifdef ADDSUB_PIPE_SAT_EN
                if (in_sat_s && ovf_s) begin
                    res_s = in_x_s[CHUNK_SIZE-1] ? {1'b1, {(WORD_SIZE-1){1'b0}}}
                                                 : {1'b0, {(WORD_SIZE-1){1'b1}}};
                end else begin
                    res_s = nsum_s;
                end
`endif
            end

            // Final stage register is the output register; ovf/cout keep the unclamped view
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_r <= {WORD_SIZE{1'b0}};
                    ovf_r <= 1'b0;
                end else if (adv_s) begin
                    sum_r <= res_s;
                    ovf_r <= ovf_s;
                end
            end
        end
    end
endmodule

// File: tb/tb_addsub_pipe.sv
// Directed self-checking bench for addsub_pipe (WORD_SIZE=16, CHUNK_SIZE=8, two stages).
module tb_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = 16'h0000;
    logic [15:0] y = 16'h0000;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic        carry = 1'b0;
`ifdef ADDSUB_PIPE_SAT_EN
    logic        sat = 1'b0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    addsub_pipe #(.WORD_SIZE(16), .CHUNK_SIZE(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .sub(sub), .cin(cin), .carry(carry),
`ifdef ADDSUB_PIPE_SAT_EN
        .sat(sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    // One isolated transaction: checks acceptance, no early result, and the result two cycles later
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic cy, input logic ci,
                          input logic [15:0] es, input logic ec, input logic eo);
        @(negedge clk);
        x = a; y = b; sub = s; carry = cy; cin = ci; in_valid = 1'b1;
        #1 chk_b({tag, ".rdy"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; x = 16'hDEAD; y = 16'hBEEF; sub = ~s; carry = ~cy; cin = ~ci;
        #1 chk_b({tag, ".early"}, out_valid, 1'b0);
        @(negedge clk);
        #1;
        chk_b({tag, ".vld"}, out_valid, 1'b1);
        chk_w({tag, ".sum"}, sum, es);
        chk_b({tag, ".cout"}, cout, ec);
        chk_b({tag, ".ovf"}, ovf, eo);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        chk_b("rst0.vld", out_valid, 1'b0);
        chk_w("rst0.sum", sum, 16'h0000);
        chk_b("rst0.cout", cout, 1'b0);
        chk_b("rst0.ovf", ovf, 1'b0);
        chk_b("rst0.rdy", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        run_op("add42_69", 16'd42, 16'd69, 1'b0, 1'b0, 1'b0, 16'd111, 1'b0, 1'b0);
        run_op("sub52_10", 16'd52, 16'd10, 1'b1, 1'b0, 1'b0, 16'd42, 1'b1, 1'b0);
        run_op("chunkcy", 16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0);
        run_op("wrapadd", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("wrapsub", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0);
        run_op("borrow", 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        run_op("subbin", 16'd5, 16'd3, 1'b1, 1'b1, 1'b0, 16'd1, 1'b1, 1'b0);
        run_op("posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("negovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
`ifdef ADDSUB_PIPE_SAT_EN
        sat = 1'b1;
        run_op("satpos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op("satneg", 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1);
        run_op("satnoovf", 16'd42, 16'd69, 1'b0, 1'b0, 1'b0, 16'd111, 1'b0, 1'b0);
        sat = 1'b0;
`endif

        // Backpressure: four back-to-back adds, consumer stalls three cycles on the first result
        @(negedge clk);
        sub = 1'b0; carry = 1'b0; cin = 1'b0;
        x = 16'd1; y = 16'd1; in_valid = 1'b1;
        @(negedge clk);
        x = 16'd2; y = 16'd2;
        @(negedge clk);
        out_ready = 1'b0; x = 16'd3; y = 16'd3;
        #1;
        chk_b("bp.vld0", out_valid, 1'b1);
        chk_w("bp.sum0", sum, 16'd2);
        chk_b("bp.rdy0", in_ready, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            #1;
            chk_b($sformatf("bp.vld%0d", i), out_valid, 1'b1);
            chk_w($sformatf("bp.sum%0d", i), sum, 16'd2);
            chk_b($sformatf("bp.rdy%0d", i), in_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk_w("bp.sum3", sum, 16'd2);
        chk_b("bp.rdy3", in_ready, 1'b1);
        @(negedge clk);
        x = 16'd4; y = 16'd4;
        #1;
        chk_b("bp.vld4", out_valid, 1'b1);
        chk_w("bp.res4", sum, 16'd4);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk_b("bp.vld6", out_valid, 1'b1);
        chk_w("bp.res6", sum, 16'd6);
        @(negedge clk);
        #1;
        chk_b("bp.vld8", out_valid, 1'b1);
        chk_w("bp.res8", sum, 16'd8);
        @(negedge clk);
        #1 chk_b("bp.nodup", out_valid, 1'b0);

        // Reset mid-flight: two sets accepted, then an asynchronous reset
        @(negedge clk);
        x = 16'd10; y = 16'd20; in_valid = 1'b1;
        @(negedge clk);
        x = 16'd30; y = 16'd40;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk_w("mid.pre", sum, 16'd30);
        rst = 1'b1;
        #1;
        chk_b("mid.vld", out_valid, 1'b0);
        chk_w("mid.sum", sum, 16'h0000);
        chk_b("mid.rdy", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk_b($sformatf("mid.none%0d", i), out_valid, 1'b0);
        end
        run_op("postrst", 16'd100, 16'd23, 1'b0, 1'b0, 1'b0, 16'd123, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
